div_sequencer: RTL and testbench

- Front-end for the iterative integer divider in the EX-stage M-extension path.
- Accepts DIV/DIVU/REM/REMU requests from EX and resolves the RISC-V special cases (divide-by-zero, signed overflow) without using the divider.
- Drives the divider with unsigned magnitudes only, then applies the sign fix-up itself.
- Reads both quotient and remainder from one divider run and keeps them in a one-entry result cache, so a DIV/REM pair on the same operands costs one division.

---
 rtl/rv32i_types.sv | 32 +++
 rtl/div_result_cache.sv | 55 +++++
 rtl/div_sequencer.sv | 156 +++++++++++++++
 tb/tb_div_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// rv32i_types : shared RV32 M-extension op codes, divide constants and the
//               divide-sequencer state encoding.
// Revision    : 1.0
// ============================================================================
package rv32i_types;

  typedef enum logic [2:0] {
    m_mul    = 3'd0,
    m_mulh   = 3'd1,
    m_mulhsu = 3'd2,
    m_mulhu  = 3'd3,
    m_div    = 3'd4,
    m_divu   = 3'd5,
    m_rem    = 3'd6,
    m_remu   = 3'd7
  } mul_ops;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    RDREM  = 3'd3,
    HOLD   = 3'd4
  } div_seq_state_t;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/div_result_cache.sv
`default_nettype none
// ============================================================================
// div_result_cache : one-entry quotient/remainder cache keyed on (a, b, signed).
// Revision         : 1.0
// ============================================================================
module div_result_cache #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_lk_a,
  input  logic [XLEN-1:0] i_lk_b,
  input  logic            i_lk_signed,
  output logic            o_hit,
  output logic [XLEN-1:0] o_q,
  output logic [XLEN-1:0] o_r,
  input  logic            i_wr_en,
  input  logic [XLEN-1:0] i_wr_a,
  input  logic [XLEN-1:0] i_wr_b,
  input  logic            i_wr_signed,
  input  logic [XLEN-1:0] i_wr_q,
  input  logic [XLEN-1:0] i_wr_r
);

  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic            r_signed;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
    end else if (i_wr_en) begin
      r_valid  <= 1'b1;
      r_a      <= i_wr_a;
      r_b      <= i_wr_b;
      r_signed <= i_wr_signed;
      r_q      <= i_wr_q;
      r_r      <= i_wr_r;
    end
  end

  assign o_hit = r_valid && (r_a == i_lk_a) && (r_b == i_lk_b) && (r_signed == i_lk_signed);
  assign o_q   = r_q;
  assign o_r   = r_r;

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// div_sequencer : DIV/DIVU/REM/REMU front-end for the unsigned iterative
//                 divider; handles RISC-V special cases, sign fix-up, caching.
// Revision      : 1.0
// ============================================================================
module div_sequencer
  import rv32i_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  mul_ops          req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  input  logic            pipeline_stalled,
  output logic            stall_o,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            div_start,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output mul_ops          div_mulop,
  output logic            div_hold,
  input  logic            div_ready,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_f
);

  div_seq_state_t  r_state;
  logic [XLEN-1:0] r_a, r_b;
  logic            r_signed, r_is_rem;
  logic [XLEN-1:0] r_mag_a, r_mag_b, r_mag_q;
  logic            r_neg_q, r_neg_r, r_drop;
  logic [XLEN-1:0] r_q, r_r;

  logic            w_is_div, w_accept, w_signed, w_is_rem, w_ovf, w_hit;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_fix_q, w_fix_r, w_cache_q, w_cache_r;

  assign w_is_div = (req_op == m_div) || (req_op == m_divu) ||
                    (req_op == m_rem) || (req_op == m_remu);
  assign w_accept = (r_state == IDLE) && req_valid && w_is_div && !flush;
  assign w_signed = (req_op == m_div) || (req_op == m_rem);
  assign w_is_rem = (req_op == m_rem) || (req_op == m_remu);
  assign w_ovf    = w_signed && (req_a == INT_MIN) && (req_b == DIV_ZERO_Q);
  assign w_abs_a  = (w_signed && req_a[XLEN-1]) ? (~req_a + 1'b1) : req_a;
  assign w_abs_b  = (w_signed && req_b[XLEN-1]) ? (~req_b + 1'b1) : req_b;

  // In RDREM the divider presents the remainder magnitude on div_f.
  assign w_fix_q  = r_neg_q ? (~r_mag_q + 1'b1) : r_mag_q;
  assign w_fix_r  = r_neg_r ? (~div_f + 1'b1) : div_f;

  div_result_cache #(.XLEN(XLEN)) u_cache (
    .clk         (clk),
    .rst         (rst),
    .i_lk_a      (req_a),
    .i_lk_b      (req_b),
    .i_lk_signed (w_signed),
    .o_hit       (w_hit),
    .o_q         (w_cache_q),
    .o_r         (w_cache_r),
    .i_wr_en     (r_state == RDREM),
    .i_wr_a      (r_a),
    .i_wr_b      (r_b),
    .i_wr_signed (r_signed),
    .i_wr_q      (w_fix_q),
    .i_wr_r      (w_fix_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_is_rem <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_mag_q  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_drop   <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= req_a;
            r_b      <= req_b;
            r_signed <= w_signed;
            r_is_rem <= w_is_rem;
            r_drop   <= 1'b0;
            if (req_b == '0) begin
              r_q     <= DIV_ZERO_Q;
              r_r     <= req_a;
              r_state <= HOLD;
            end else if (w_ovf) begin
              r_q     <= INT_MIN;
              r_r     <= '0;
              r_state <= HOLD;
            end else if (w_hit) begin
              r_q     <= w_cache_q;
              r_r     <= w_cache_r;
              r_state <= HOLD;
            end else begin
              r_mag_a <= w_abs_a;
              r_mag_b <= w_abs_b;
              r_neg_q <= w_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
              r_neg_r <= w_signed && req_a[XLEN-1];
              r_state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (flush)          r_state <= IDLE;
          else if (div_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (flush) r_drop <= 1'b1;
          if (div_done) begin
            r_mag_q <= div_f;
            r_state <= RDREM;
          end
        end
        RDREM: begin
          r_q     <= w_fix_q;
          r_r     <= w_fix_r;
          r_drop  <= 1'b0;
          // A squashed request still fills the cache but never presents a result.
          r_state <= (r_drop || flush) ? IDLE : HOLD;
        end
        HOLD: begin
          if (flush || !pipeline_stalled) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign div_start    = (r_state == LAUNCH) && div_ready && !flush;
  assign div_hold     = (r_state == WAIT) || (r_state == RDREM);
  assign div_mulop    = (r_state == RDREM) ? m_remu : m_divu;
  assign div_a        = r_mag_a;
  assign div_b        = r_mag_b;
  assign result_valid = (r_state == HOLD) && !flush;
  assign result       = (r_state == HOLD) ? (r_is_rem ? r_r : r_q) : '0;
  assign stall_o      = w_accept ||
                        ((r_state != IDLE) &&
                         !((r_state == HOLD) && (!pipeline_stalled || flush)));

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// tb_div_sequencer : directed scoreboard bench with a behavioural divider.
// Revision         : 1.0
// ============================================================================
module tb_div_sequencer;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  mul_ops      req_op = m_mul;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        pipeline_stalled = 1'b0;
  logic        stall_o, result_valid, div_start, div_hold, div_ready, div_done;
  logic [31:0] result, div_a, div_b, div_f;
  mul_ops      div_mulop;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .pipeline_stalled(pipeline_stalled), .stall_o(stall_o),
    .result_valid(result_valid), .result(result), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_mulop(div_mulop), .div_hold(div_hold),
    .div_ready(div_ready), .div_done(div_done), .div_f(div_f)
  );

  // Behavioural unsigned divider: fixed latency, result held while div_hold.
  logic        m_busy, m_done;
  int          m_cnt;
  logic [31:0] m_a, m_b;
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_a <= '0; m_b <= '0;
    end else if (div_start && !m_busy && !m_done) begin
      m_busy <= 1'b1; m_cnt <= 5; m_a <= div_a; m_b <= div_b;
    end else if (m_busy) begin
      if (m_cnt == 0) begin m_busy <= 1'b0; m_done <= 1'b1; end
      else m_cnt <= m_cnt - 1;
    end else if (m_done && !div_hold) begin
      m_done <= 1'b0;
    end
  end
  always @(posedge clk) if (!rst && div_start) start_cnt <= start_cnt + 1;
  assign div_ready = !m_busy && !m_done;
  assign div_done  = m_done;
  assign div_f     = (m_b == 32'd0) ? 32'hFFFF_FFFF :
                     ((div_mulop == m_remu) ? (m_a % m_b) : (m_a / m_b));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one request, wait for its result, hold it for n_stall cycles.
  task automatic run_req(input string name, input mul_ops op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int n_stall, input bit fast);
    int s0, n;
    logic [31:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    pipeline_stalled = (n_stall > 0);
    sb.push_back(exp);
    s0 = start_cnt;
    #1 check({name, ".stall_acc"}, {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_op = m_mul;
    n = 1;
    while (!result_valid && n < 200) begin @(negedge clk); n++; end
    check({name, ".valid"}, {31'd0, result_valid}, 32'd1);
    if (fast) begin
      check({name, ".latency"}, n, 32'd1);
      check({name, ".no_start"}, start_cnt - s0, 32'd0);
    end else begin
      check({name, ".one_start"}, start_cnt - s0, 32'd1);
    end
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    for (int i = 0; i < n_stall; i++) begin
      check({name, ".result_hold"}, result, e);
      check({name, ".stall_hold"}, {31'd0, stall_o}, 32'd1);
      @(negedge clk);
    end
    pipeline_stalled = 1'b0;
    #1;
    check({name, ".result"}, result, e);
    check({name, ".valid_final"}, {31'd0, result_valid}, 32'd1);
    check({name, ".stall_release"}, {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    check({name, ".idle_after"}, {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    int s0, n;
    bit saw_valid;
    repeat (3) @(negedge clk);
    check("rst.stall", {31'd0, stall_o}, 32'd0);
    check("rst.valid", {31'd0, result_valid}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.start", {31'd0, div_start}, 32'd0);
    check("rst.hold", {31'd0, div_hold}, 32'd0);
    check("rst.div_a", div_a, 32'd0);
    check("rst.div_b", div_b, 32'd0);
    check("rst.mulop", {29'd0, div_mulop}, {29'd0, m_divu});
    rst = 1'b0;
    @(negedge clk);

    run_req("divu_100_7", m_divu, 32'd100, 32'd7, 32'd14, 0, 1'b0);
    run_req("remu_100_7_hit", m_remu, 32'd100, 32'd7, 32'd2, 0, 1'b1);
    run_req("div_m7_2", m_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1'b0);
    run_req("rem_7_m2", m_rem, 32'd7, 32'hFFFF_FFFE, 32'd1, 0, 1'b0);
    run_req("div_5_0", m_div, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
    run_req("remu_5_0", m_remu, 32'd5, 32'd0, 32'd5, 0, 1'b1);
    run_req("div_ovf", m_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b1);
    run_req("rem_ovf", m_rem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b1);
    run_req("divu_1000_3_stall", m_divu, 32'd1000, 32'd3, 32'd333, 4, 1'b0);

    // Non-divide op must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = m_mul; req_a = 32'd9; req_b = 32'd3;
    #1 check("mul_ignored.stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("mul_ignored.valid", {31'd0, result_valid}, 32'd0);

    // Flush mid-division: no result, cache still filled.
    @(negedge clk);
    req_valid = 1'b1; req_op = m_divu; req_a = 32'd50; req_b = 32'd5;
    s0 = start_cnt;
    @(negedge clk);
    req_valid = 1'b0; req_op = m_mul;
    n = 0;
    while (start_cnt == s0 && n < 50) begin @(negedge clk); n++; end
    check("flush.started", start_cnt - s0, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    saw_valid = 1'b0;
    n = 0;
    while (stall_o && n < 100) begin
      saw_valid |= result_valid;
      @(negedge clk); n++;
    end
    check("flush.no_valid", {31'd0, saw_valid}, 32'd0);
    check("flush.stall_drop", {31'd0, stall_o}, 32'd0);
    check("flush.one_start", start_cnt - s0, 32'd1);
    repeat (2) @(negedge clk);
    run_req("remu_50_5_hit", m_remu, 32'd50, 32'd5, 32'd0, 0, 1'b1);

    check("sb.empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
